// File: rtl/sha_miner_pkg.sv
// Shared types, widths and byte-order helpers for the SHA-256d miner datapath.
package sha_miner_pkg;

  localparam int HDR_W    = 640;
  localparam int DIG_W    = 256;
  localparam int PREFIX_W = 608;
  localparam int NONCE_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_FIN
  } state_e;

  function automatic logic [NONCE_W-1:0] byte_swap32(input logic [NONCE_W-1:0] x);
    logic [NONCE_W-1:0] y;
    y = '0;
    for (int i = 0; i < NONCE_W / 8; i++) begin
      y[8*i +: 8] = x[NONCE_W - 8 - 8*i +: 8];
    end
    return y;
  endfunction

  function automatic logic [DIG_W-1:0] byte_swap256(input logic [DIG_W-1:0] x);
    logic [DIG_W-1:0] y;
    y = '0;
    for (int i = 0; i < DIG_W / 8; i++) begin
      y[8*i +: 8] = x[DIG_W - 8 - 8*i +: 8];
    end
    return y;
  endfunction

endpackage

// File: rtl/nonce_sequencer_target_compare.sv
// Byte-swaps a digest into numeric order and tests it against the target (unsigned <=).
module target_compare
  import sha_miner_pkg::*;
(
  input  logic [DIG_W-1:0] digest,
  input  logic [DIG_W-1:0] target,
  output logic             win
);

  logic [DIG_W-1:0] digest_num;

  always_comb begin
    digest_num = byte_swap256(digest);
    win        = (digest_num <= target);
  end

endmodule

// File: rtl/nonce_sequencer.sv
// Job controller: walks a nonce range, issues one header per nonce to the hash core
// and stops on the first digest that meets the target or when the range runs out.
module nonce_sequencer
  import sha_miner_pkg::*;
#(
  parameter int CNT_W = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [PREFIX_W-1:0] job_prefix,
  input  logic [DIG_W-1:0]    target,
  input  logic [NONCE_W-1:0]  nonce_start,
  input  logic [NONCE_W-1:0]  nonce_end,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [HDR_W-1:0]    req_header,
  input  logic                rsp_valid,
  input  logic [DIG_W-1:0]    rsp_digest,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic [CNT_W-1:0]    hash_count
);

  state_e               state_q, state_d;
  logic [PREFIX_W-1:0]  prefix_q, prefix_d;
  logic [DIG_W-1:0]     target_q, target_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic [NONCE_W-1:0]   nonce_end_q, nonce_end_d;
  logic [DIG_W-1:0]     digest_q, digest_d;
  logic                 drain_q, drain_d;
  logic                 found_q, found_d;
  logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
  logic [CNT_W-1:0]     hash_count_q, hash_count_d;
  logic                 req_valid_q, req_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 win;

  target_compare u_cmp (
    .digest (digest_q),
    .target (target_q),
    .win    (win)
  );

  always_comb begin
    state_d       = state_q;
    prefix_d      = prefix_q;
    target_d      = target_q;
    nonce_d       = nonce_q;
    nonce_end_d   = nonce_end_q;
    digest_d      = digest_q;
    drain_d       = drain_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    hash_count_d  = hash_count_q;

    unique case (state_q)
      ST_IDLE: begin
        // A drain only ever exists in IDLE: the orphaned response is swallowed here.
        if (drain_q && rsp_valid) begin
          drain_d = 1'b0;
        end
        if (start && !abort && !drain_q) begin
          prefix_d      = job_prefix;
          target_d      = target;
          nonce_d       = nonce_start;
          nonce_end_d   = nonce_end;
          found_d       = 1'b0;
          found_nonce_d = '0;
          hash_count_d  = '0;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d = ST_IDLE;
          if (req_ready) drain_d = 1'b1;
        end else if (req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response landing in the abort cycle is already consumed, so no drain is owed.
        if (abort) begin
          state_d = ST_IDLE;
          if (!rsp_valid) drain_d = 1'b1;
        end else if (rsp_valid) begin
          digest_d = rsp_digest;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          if (hash_count_q != {CNT_W{1'b1}}) begin
            hash_count_d = hash_count_q + CNT_W'(1);
          end
          if (win) begin
            found_d       = 1'b1;
            found_nonce_d = nonce_q;
            state_d       = ST_FIN;
          end else if (nonce_q == nonce_end_q) begin
            state_d = ST_FIN;
          end else begin
            nonce_d = nonce_q + NONCE_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_valid_d = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE) || drain_d;
    done_d      = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      prefix_q      <= '0;
      target_q      <= '0;
      nonce_q       <= '0;
      nonce_end_q   <= '0;
      digest_q      <= '0;
      drain_q       <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      hash_count_q  <= '0;
      req_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prefix_q      <= prefix_d;
      target_q      <= target_d;
      nonce_q       <= nonce_d;
      nonce_end_q   <= nonce_end_d;
      digest_q      <= digest_d;
      drain_q       <= drain_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      hash_count_q  <= hash_count_d;
      req_valid_q   <= req_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign req_valid   = req_valid_q;
  assign req_header  = {prefix_q, byte_swap32(nonce_q)};
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign hash_count  = hash_count_q;

endmodule
